matram_port_arbiter: RTL

//   Shares the single MatRAM access port between NUM_REQ MatRAM lane controllers.

---
 rtl/matram_port_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/matram_port_arbiter.sv
// matram_port_arbiter
//   Shares the single MatRAM port between NUM_REQ lane controllers. Lanes are
//   granted round-robin. The burst addresses of the lane that owns the grant
//   are sequenced onto the port. A done pulse is returned on the final beat.
// Ports
//   i_clk, i_reset : clock (rising edge), synchronous active-high reset
//   i_req          : per-lane request level, held until done or abort
//   i_req_addr     : per-lane burst start address, lane i at [i*ADDR_W +: ADDR_W]
//   i_req_len      : per-lane burst length minus one, lane i at [i*LEN_W +: LEN_W]
//   i_req_we       : per-lane direction, 1 = write
//   o_gnt          : one-hot grant, high on every beat of the owner's burst
//   o_done         : one-cycle pulse to the owner on its final beat
//   o_ram_en       : MatRAM port enable
//   o_ram_we       : MatRAM write enable
//   o_ram_addr     : MatRAM address
//   o_busy         : high while a burst is in progress
module matram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  i_req_len,
  input  logic [NUM_REQ-1:0]        i_req_we,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_done,
  output logic                      o_ram_en,
  output logic                      o_ram_we,
  output logic [ADDR_W-1:0]         o_ram_addr,
  output logic                      o_busy
);

  localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NREQ  = NUM_REQ;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned     step);
    int unsigned sum;
    sum = 32'(base) + step;
    if (sum >= NREQ) sum = sum - NREQ;
    return PTR_W'(sum);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic [ADDR_W-1:0]   r_base;
  logic [LEN_W-1:0]    r_len;
  logic                r_we;
  logic [LEN_W-1:0]    r_beat;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_done;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;

  logic                w_found;
  logic [PTR_W-1:0]    w_sel;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [LEN_W-1:0]    w_sel_len;
  logic [LEN_W-1:0]    w_beat_inc;

  state_t              w_state_n;
  logic [PTR_W-1:0]    w_ptr_n;
  logic [PTR_W-1:0]    w_owner_n;
  logic [ADDR_W-1:0]   w_base_n;
  logic [LEN_W-1:0]    w_len_n;
  logic                w_we_n;
  logic [LEN_W-1:0]    w_beat_n;
  logic [NUM_REQ-1:0]  w_gnt_n;
  logic [NUM_REQ-1:0]  w_done_n;
  logic                w_ram_en_n;
  logic                w_ram_we_n;
  logic [ADDR_W-1:0]   w_ram_addr_n;

  // First requesting lane at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[wrap_idx(r_ptr, i)]) begin
        w_found = 1'b1;
        w_sel   = wrap_idx(r_ptr, i);
      end
    end
  end

  assign w_sel_addr = i_req_addr[w_sel*ADDR_W +: ADDR_W];
  assign w_sel_len  = i_req_len[w_sel*LEN_W +: LEN_W];
  assign w_beat_inc = r_beat + 1'b1;

  // Outputs are computed one cycle ahead so that each beat is registered
  // together with the state that owns it; the grant edge therefore already
  // presents beat 0.
  always_comb begin
    w_state_n    = r_state;
    w_ptr_n      = r_ptr;
    w_owner_n    = r_owner;
    w_base_n     = r_base;
    w_len_n      = r_len;
    w_we_n       = r_we;
    w_beat_n     = r_beat;
    w_gnt_n      = '0;
    w_done_n     = '0;
    w_ram_en_n   = 1'b0;
    w_ram_we_n   = 1'b0;
    w_ram_addr_n = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_n    = S_BURST;
          w_owner_n    = w_sel;
          w_base_n     = w_sel_addr;
          w_len_n      = w_sel_len;
          w_we_n       = i_req_we[w_sel];
          w_beat_n     = '0;
          w_ptr_n      = wrap_idx(w_sel, 1);
          w_gnt_n      = onehot(w_sel);
          w_ram_en_n   = 1'b1;
          w_ram_we_n   = i_req_we[w_sel];
          w_ram_addr_n = w_sel_addr;
          if (w_sel_len == '0) w_done_n = onehot(w_sel);
        end
      end
      S_BURST: begin
        // Abort or final beat shown this cycle: drop back to IDLE outputs.
        if (!i_req[r_owner] || (r_beat == r_len)) begin
          w_state_n = S_IDLE;
        end else begin
          w_beat_n     = w_beat_inc;
          w_gnt_n      = onehot(r_owner);
          w_ram_en_n   = 1'b1;
          w_ram_we_n   = r_we;
          w_ram_addr_n = r_base + ADDR_W'(w_beat_inc);
          if (w_beat_inc == r_len) w_done_n = onehot(r_owner);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_base     <= '0;
      r_len      <= '0;
      r_we       <= 1'b0;
      r_beat     <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
    end else begin
      r_state    <= w_state_n;
      r_ptr      <= w_ptr_n;
      r_owner    <= w_owner_n;
      r_base     <= w_base_n;
      r_len      <= w_len_n;
      r_we       <= w_we_n;
      r_beat     <= w_beat_n;
      r_gnt      <= w_gnt_n;
      r_done     <= w_done_n;
      r_ram_en   <= w_ram_en_n;
      r_ram_we   <= w_ram_we_n;
      r_ram_addr <= w_ram_addr_n;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_done     = r_done;
  assign o_ram_en   = r_ram_en;
  assign o_ram_we   = r_ram_we;
  assign o_ram_addr = r_ram_addr;
  assign o_busy     = (r_state == S_BURST);

endmodule
